systolic_result_drain: RTL
==========================

# systolic_result_drain

Downstream drain stage for the int8 systolic array. When a tile finishes accumulating, it snapshots all N×N 32-bit PE accumulators in one cycle and then clears the array via `accum_reset`. It streams the snapshot out in row-major order over a valid/ready interface, one element per handshake, with both raw and requantized int8 values. This frees the array to start the next tile while the previous tile is still draining.

## Interface
Parameters:
- `N`, 4: array dimension; N×N elements per tile.
- `ACCUM_WIDTH`, 32: PE accumulator width, signed.
- `OUT_WIDTH`, 8: requantized output width, signed.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `capture` in 1: tile-complete pulse from the tile controller.
- `shift` in 5: requant right-shift amount, 0..31; sampled on an accepted capture.
- `results_flat` in N*N*ACCUM_WIDTH: PE(r,c) result at `[(r*N+c)*ACCUM_WIDTH +: ACCUM_WIDTH]`.
- `accum_reset` out 1: clear pulse to every PE.
- `busy` out 1: high while in DRAIN.
- `out_valid` out 1: output element valid.
- `out_ready` in 1: downstream accepts.
- `out_acc` out ACCUM_WIDTH: raw accumulator value.
- `out_q` out OUT_WIDTH: rounded, shifted, saturated value.
- `out_row`, `out_col` out $clog2(N) each: element coordinates.
- `out_last` out 1: high with element (N-1,N-1).
- `done` out 1: one-cycle pulse after the last handshake.
- `overrun` out 1: sticky; set when a capture is dropped. Cleared only by rst.

## Operation
- States: IDLE, DRAIN.
- Capture acceptance:
  - A capture is accepted when `capture`=1 and the block is in IDLE, or in DRAIN with the final handshake occurring in the same cycle (back-to-back tiles).
  - On acceptance: latch `results_flat` into the snapshot buffer, latch `shift`, reset the index to 0, and go to (or stay in) DRAIN.
- Dropped captures: `capture` in DRAIN without a final handshake is ignored and sets `overrun`. The buffer is unchanged.
- Handshake: a transfer occurs when `out_valid && out_ready`. Each transfer advances the index row-major, incrementing col and then row.
- Last element: the handshake on (N-1,N-1) returns the block to IDLE, unless a capture is accepted in that same cycle.
- `out_valid` must never drop while in DRAIN before the last handshake. `out_*` fields hold stable while `out_valid && !out_ready`.
- Requant (`shift` = s, signed arithmetic, ACCUM_WIDTH+1-bit intermediate so no overflow):
  - s=0: q = acc.
  - s>0: q = (acc + 2^(s-1)) >>> s, i.e. round half up.
  - Saturate q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- `out_acc` is the snapshot value, unmodified.

## Timing
- Reset values: state IDLE, `accum_reset`=0, `busy`=0, `out_valid`=0, `out_last`=0, `done`=0, `overrun`=0, index 0. `out_acc`, `out_q`, `out_row`, `out_col` reset to 0.
- Capture accepted in cycle t:
  - Snapshot is taken at the edge ending t.
  - `accum_reset`=1 for exactly cycle t+1.
  - `busy`=1 and `out_valid`=1 with element (0,0) from cycle t+1.
  - The PEs must therefore present final results in cycle t. The array may restart accumulation in t+2.
- Throughput: one element per cycle when `out_ready` is held high. A tile drains in N² cycles.
- Last handshake in cycle u with no new capture: `out_valid`=0, `busy`=0 and `done`=1 in u+1.
- Back-to-back: a capture accepted in the last-handshake cycle u gives element (0,0) of the new tile in u+1 with no bubble. `done` still pulses in u+1, and `accum_reset` pulses in u+1.
- `out_q`/`out_acc` are registered and must be valid in the same cycle as `out_valid`. Any requant pipelining must be hidden, e.g. by prefetching the next index.
- rst mid-drain: the drain aborts immediately, the snapshot is discarded, and all outputs take their reset values on the next cycle. No `accum_reset` or `done` is issued.

## Structure
- Shared package `systolic_pkg`: `ACCUM_WIDTH`, `DATA_WIDTH`, `OUT_WIDTH` constants; drain state enum (IDLE, DRAIN); coordinate-width function `clog2(N)`.
- Sub-module `requant_sat`: combinational round, shift and saturate. Parameters `ACCUM_WIDTH`, `OUT_WIDTH`; ports `acc`, `shift`, `q`.
- Top level holds the snapshot buffer, index counters, FSM and output registers.

## Test plan
- N=2, results {1000, -1000, 127, 300}, shift=3, `out_ready`=1:
  - out_q sequence is 125, -125, 16, 38.
  - out_acc matches the inputs.
  - out_last only on the 4th element; done the cycle after; accum_reset one cycle after capture.
- Saturation, shift=0, acc = 2^31-1 and -2^31: out_q = 127 and -128.
- Backpressure:
  - Toggle out_ready 1,0,0,1,…: every element is transferred exactly once, in order.
  - Fields stay stable during stalls; busy stays 1 throughout.
- Back-to-back tiles:
  - Assert capture in the same cycle as the last handshake: the next tile's (0,0) appears the following cycle.
  - overrun stays 0; accum_reset pulses once per tile.
- Overrun:
  - Capture during mid-drain: overrun=1 (sticky).
  - Drained data equals the first snapshot, unaffected by changes to `results_flat`.
- Reset on element 2 of 4: the next cycle has out_valid=0, busy=0, done=0. A fresh capture then drains normally from (0,0).

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants, drain FSM state type and coordinate-width helper for the
// int8 systolic array datapath.
package systolic_pkg;

  localparam int ACCUM_WIDTH = 32;
  localparam int DATA_WIDTH  = 8;
  localparam int OUT_WIDTH   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // Minimum of 1 so a degenerate N=1 array still gets a legal port width.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: round half up, arithmetic right shift, then
// saturate the signed accumulator into the signed output range.
module requant_sat #(
  parameter int ACCUM_WIDTH = systolic_pkg::ACCUM_WIDTH,
  parameter int OUT_WIDTH   = systolic_pkg::OUT_WIDTH
) (
  input  logic [ACCUM_WIDTH-1:0] acc,
  input  logic [4:0]             shift,
  output logic [OUT_WIDTH-1:0]   q
);

  localparam int EW = ACCUM_WIDTH + 1;

  localparam logic signed [EW-1:0] QMAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] QMIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] bias;
  logic signed [EW-1:0] rounded;

  // One guard bit keeps acc + 2^(s-1) from wrapping at the positive limit.
  always_comb begin
    ext  = $signed({acc[ACCUM_WIDTH-1], acc});
    bias = '0;
    if (shift != 5'd0) begin
      bias = EW'(1) << (shift - 5'd1);
    end
    rounded = (ext + bias) >>> shift;
    if (rounded > QMAX) begin
      q = QMAX[OUT_WIDTH-1:0];
    end else if (rounded < QMIN) begin
      q = QMIN[OUT_WIDTH-1:0];
    end else begin
      q = rounded[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the PE accumulators on tile completion, clears the array, and
// streams the snapshot out row-major with raw and requantized values.
module systolic_result_drain #(
  parameter int N           = 4,
  parameter int ACCUM_WIDTH = systolic_pkg::ACCUM_WIDTH,
  parameter int OUT_WIDTH   = systolic_pkg::OUT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                capture,
  input  logic [4:0]                          shift,
  input  logic [N*N*ACCUM_WIDTH-1:0]          results_flat,
  output logic                                accum_reset,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ACCUM_WIDTH-1:0]              out_acc,
  output logic [OUT_WIDTH-1:0]                out_q,
  output logic [systolic_pkg::clog2(N)-1:0]   out_row,
  output logic [systolic_pkg::clog2(N)-1:0]   out_col,
  output logic                                out_last,
  output logic                                done,
  output logic                                overrun
);

  import systolic_pkg::*;

  localparam int NE  = N * N;
  localparam int CW  = clog2(N);
  localparam int AIW = clog2(NE);

  drain_state_e             state_q;
  logic [ACCUM_WIDTH-1:0]   snap_q [NE];
  logic [4:0]               shift_q;
  logic [CW-1:0]            row_q;
  logic [CW-1:0]            col_q;
  logic [ACCUM_WIDTH-1:0]   acc_q;
  logic [OUT_WIDTH-1:0]     qo_q;
  logic                     last_q;
  logic                     done_q;
  logic                     ar_q;
  logic                     ovr_q;

  logic                     fire;
  logic                     last_fire;
  logic                     accept;
  logic                     drop;
  logic [CW-1:0]            row_d;
  logic [CW-1:0]            col_d;
  logic                     last_d;
  logic [AIW-1:0]           addr_d;
  logic [ACCUM_WIDTH-1:0]   rq_acc;
  logic [4:0]               rq_shift;
  logic [OUT_WIDTH-1:0]     rq_q;

  always_comb begin
    fire      = (state_q == DRAIN) && out_ready;
    last_fire = fire && last_q;
    accept    = capture && ((state_q == IDLE) || last_fire);
    drop      = capture && (state_q == DRAIN) && !last_fire;
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (col_q == CW'(N - 1)) begin
      col_d = '0;
      row_d = row_q + CW'(1);
    end else begin
      col_d = col_q + CW'(1);
    end
    last_d = (row_d == CW'(N - 1)) && (col_d == CW'(N - 1));
    addr_d = AIW'(int'(row_d) * N + int'(col_d));
  end

  // The requantizer works one element ahead of the output registers: on a
  // capture it sees element (0,0) straight from the array, otherwise the
  // next snapshot element, so out_q is ready together with out_valid.
  always_comb begin
    rq_acc   = snap_q[addr_d];
    rq_shift = shift_q;
    if (accept) begin
      rq_acc   = results_flat[ACCUM_WIDTH-1:0];
      rq_shift = shift;
    end
  end

  requant_sat #(
    .ACCUM_WIDTH (ACCUM_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH)
  ) u_requant (
    .acc   (rq_acc),
    .shift (rq_shift),
    .q     (rq_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      qo_q    <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ar_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ar_q   <= accept;
      done_q <= last_fire;
      if (drop) begin
        ovr_q <= 1'b1;
      end
      if (accept) begin
        for (int unsigned i = 0; i < NE; i++) begin
          snap_q[i] <= results_flat[i*ACCUM_WIDTH +: ACCUM_WIDTH];
        end
        shift_q <= shift;
        state_q <= DRAIN;
        row_q   <= '0;
        col_q   <= '0;
        acc_q   <= rq_acc;
        qo_q    <= rq_q;
        last_q  <= 1'(NE == 1);
      end else if (last_fire) begin
        state_q <= IDLE;
        last_q  <= 1'b0;
      end else if (fire) begin
        row_q  <= row_d;
        col_q  <= col_d;
        acc_q  <= snap_q[addr_d];
        qo_q   <= rq_q;
        last_q <= last_d;
      end
    end
  end

  assign busy        = (state_q == DRAIN);
  assign out_valid   = (state_q == DRAIN);
  assign accum_reset = ar_q;
  assign done        = done_q;
  assign overrun     = ovr_q;
  assign out_acc     = acc_q;
  assign out_q       = qo_q;
  assign out_row     = row_q;
  assign out_col     = col_q;
  assign out_last    = last_q;

endmodule
